// File: rtl/pu_select_pkg.sv
// Shared definitions for the select processing unit: FSM states and the
// attribute bit index shared across all PUs.
package pu_select_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_COND = 2'd1,
        GOT_A    = 2'd2,
        DONE     = 2'd3
    } sel_state_e;

    localparam int ATTR_INVALID = 0;

endpackage

// File: rtl/pu_select.sv
// Select PU: captures cond, A, B in order over the shared write bus and
// presents cond ? A : B, with invalid-attribute propagation, on output enable.
module pu_select
    import pu_select_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int INVALID    = ATTR_INVALID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out
);

    sel_state_e            state_q;
    logic                  cond_q;
    logic                  cond_inv_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic                  a_inv_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic [ATTR_WIDTH-1:0] res_attr_q;

    logic [DATA_WIDTH-1:0] res_d;
    logic [ATTR_WIDTH-1:0] res_attr_d;

    // Only the invalid bit of an argument's attributes carries meaning here.
    logic unused_attr;
    assign unused_attr = ^attr_in;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        res_d               = cond_q ? a_q : data_in;
        res_attr_d          = '0;
        res_attr_d[INVALID] = cond_inv_q | (cond_q ? a_inv_q : attr_in[INVALID]);
    end

    // NOTE: state uses non-blocking assignments and an async active-low reset, so partial argument sequences are dropped immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cond_q     <= 1'b0;
            cond_inv_q <= 1'b0;
            a_q        <= '0;
            a_inv_q    <= 1'b0;
            res_q      <= '0;
            res_attr_q <= '0;
        end else if (signal_wr) begin
            case (state_q)
                IDLE, DONE: begin
                    cond_q     <= |data_in;
                    cond_inv_q <= attr_in[INVALID];
                    state_q    <= GOT_COND;
                end
                GOT_COND: begin
                    a_q     <= data_in;
                    a_inv_q <= attr_in[INVALID];
                    state_q <= GOT_A;
                end
                GOT_A: begin
                    res_q      <= res_d;
                    res_attr_q <= res_attr_d;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out = signal_oe ? res_q      : '0;
    assign attr_out = signal_oe ? res_attr_q : '0;

endmodule

// File: tb/tb_pu_select.sv
// Self-checking bench for pu_select: a transaction-level model of the
// cond/A/B protocol plus directed vectors with literal expectations.
module tb_pu_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        signal_wr;
    logic [31:0] data_in;
    logic [3:0]  attr_in;
    logic        signal_oe;
    logic [31:0] data_out;
    logic [3:0]  attr_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: arguments of the current sequence and the last completed result.
    int          m_idx = 0;
    logic [31:0] m_arg [3];
    logic        m_inv [3];
    logic [31:0] m_res  = '0;
    logic [3:0]  m_attr = '0;

    pu_select #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .INVALID(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .signal_wr (signal_wr),
        .data_in   (data_in),
        .attr_in   (attr_in),
        .signal_oe (signal_oe),
        .data_out  (data_out),
        .attr_out  (attr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_res  = '0;
        m_attr = '0;
    endtask

    task automatic model_write(input logic [31:0] d, input logic [3:0] a);
        m_arg[m_idx] = d;
        m_inv[m_idx] = a[0];
        if (m_idx == 2) begin
            m_res  = (m_arg[0] != 0) ? m_arg[1] : m_arg[2];
            m_attr = {3'b000, m_inv[0] | ((m_arg[0] != 0) ? m_inv[1] : m_inv[2])};
            m_idx  = 0;
        end else begin
            m_idx++;
        end
    endtask

    task automatic wr(input logic [31:0] d, input logic [3:0] a);
        signal_wr = 1'b1;
        data_in   = d;
        attr_in   = a;
        @(posedge clk);
        model_write(d, a);
        #1;
        signal_wr = 1'b0;
        data_in   = '0;
        attr_in   = '0;
    endtask

    task automatic seq(input logic [31:0] c, input logic [3:0] ca,
                       input logic [31:0] a, input logic [3:0] aa,
                       input logic [31:0] b, input logic [3:0] ba);
        wr(c, ca);
        wr(a, aa);
        wr(b, ba);
    endtask

    task automatic rd(input string name, input logic [31:0] exp_d, input logic [3:0] exp_a);
        signal_oe = 1'b1;
        @(negedge clk);
        check({name, "_data"}, data_out, exp_d);
        check({name, "_attr"}, {28'd0, attr_out}, {28'd0, exp_a});
        @(posedge clk);
        #1;
        signal_oe = 1'b0;
    endtask

    // Asynchronous reset pulse dropped mid-cycle, released off the clock edge.
    task automatic rst_pulse(input string name);
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check({name, "_async_data"}, data_out, 32'd0);
        check({name, "_async_attr"}, {28'd0, attr_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Continuous comparison against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_data", data_out, (rst && signal_oe) ? m_res : 32'd0);
            check("cmp_attr", {28'd0, attr_out}, (rst && signal_oe) ? {28'd0, m_attr} : 32'd0);
        end
    end

    initial begin
        rst       = 1'b0;
        signal_wr = 1'b0;
        data_in   = '0;
        attr_in   = '0;
        signal_oe = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_data", data_out, 32'd0);
            check("reset_attr", {28'd0, attr_out}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        signal_oe = 1'b0;

        rd("before_first", 32'd0, 4'b0000);

        seq(32'd1, 4'b0000, 32'h0000_00AA, 4'b0000, 32'h0000_00BB, 4'b0000);
        rd("true_sel", 32'h0000_00AA, 4'b0000);

        seq(32'd0, 4'b0000, 32'h0000_00AA, 4'b0000, 32'h0000_00BB, 4'b0000);
        rd("false_sel", 32'h0000_00BB, 4'b0000);

        seq(32'h8000_0000, 4'b0000, 32'h0000_00AA, 4'b0000, 32'h0000_00BB, 4'b0000);
        rd("wide_cond", 32'h0000_00AA, 4'b0000);

        seq(32'd1, 4'b0000, 32'h0000_00AA, 4'b0001, 32'h0000_00BB, 4'b0000);
        rd("a_inv_sel", 32'h0000_00AA, 4'b0001);

        seq(32'd0, 4'b0000, 32'h0000_00AA, 4'b0001, 32'h0000_00BB, 4'b0000);
        rd("a_inv_unsel", 32'h0000_00BB, 4'b0000);

        seq(32'd0, 4'b0001, 32'h0000_00AA, 4'b0000, 32'h0000_00BB, 4'b0000);
        rd("cond_inv_b", 32'h0000_00BB, 4'b0001);

        seq(32'd1, 4'b0001, 32'h0000_00AA, 4'b0000, 32'h0000_00BB, 4'b0000);
        rd("cond_inv_a", 32'h0000_00AA, 4'b0001);

        // Only the invalid bit survives into the result attributes.
        seq(32'd1, 4'b1110, 32'h0000_00CC, 4'b1110, 32'h0000_00DD, 4'b1110);
        rd("attr_mask", 32'h0000_00CC, 4'b0000);

        // Retention while a new sequence is partly written, then overlapped B write.
        seq(32'd1, 4'b0000, 32'h0000_00AA, 4'b0000, 32'h0000_00BB, 4'b0000);
        wr(32'd0, 4'b0000);
        wr(32'd1, 4'b0000);
        rd("retain", 32'h0000_00AA, 4'b0000);
        signal_wr = 1'b1;
        data_in   = 32'h0000_0055;
        attr_in   = 4'b0000;
        signal_oe = 1'b1;
        @(negedge clk);
        check("overlap_pre", data_out, 32'h0000_00AA);
        @(posedge clk);
        model_write(32'h0000_0055, 4'b0000);
        #1;
        signal_wr = 1'b0;
        data_in   = '0;
        @(negedge clk);
        check("overlap_post", data_out, 32'h0000_0055);
        @(posedge clk);
        #1;

        // Async reset with a result on the bus: outputs clear before the next edge.
        signal_oe = 1'b1;
        rst_pulse("live");
        signal_oe = 1'b0;
        rd("after_reset", 32'd0, 4'b0000);

        // Reset mid-sequence discards cond and A.
        wr(32'd1, 4'b0000);
        wr(32'h0000_0011, 4'b0000);
        rst_pulse("mid");
        seq(32'd0, 4'b0000, 32'h0000_0022, 4'b0000, 32'h0000_0033, 4'b0000);
        rd("restart", 32'h0000_0033, 4'b0000);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/pu_select.md
Name: pu_select

Overview:
- Processing unit directly downstream of the compare PU.
- Consumes the compare result as a condition word, then two operands A and B.
- Produces the registered output cond ? A : B on the shared data/attr bus.
- Same write/output-enable protocol as the other PUs, so conditional dataflow (if/select) needs no control-path branching.

Parameters:
- DATA_WIDTH, 32, width of data_in/data_out.
- ATTR_WIDTH, 4, width of attr_in/attr_out, minimum 2.
- INVALID, 0, index of the invalid-value attribute bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserted when 0.
- signal_wr  input  1  write strobe; one argument captured per asserted cycle.
- data_in  input  DATA_WIDTH  argument value.
- attr_in  input  ATTR_WIDTH  argument attributes; bit INVALID marks the value invalid.
- signal_oe  input  1  output enable for the result.
- data_out  output  DATA_WIDTH  selected value when signal_oe=1, else all zeros.
- attr_out  output  ATTR_WIDTH  result attributes when signal_oe=1, else all zeros.

Behaviour:
- Reset (rst=0, asynchronous)
  - Takes effect immediately; state=IDLE; cond, a, a_inv, res, res_attr all cleared.
  - data_out=0, attr_out=0 regardless of signal_oe.
  - A reset mid-sequence discards all partially written arguments.
- Argument order is fixed: cond, A, B. States IDLE -> GOT_COND -> GOT_A -> DONE.
- IDLE or DONE, signal_wr=1: cond <= |data_in; cond_inv <= attr_in[INVALID]; next GOT_COND. In DONE, res/res_attr are retained until overwritten.
- GOT_COND, signal_wr=1: a <= data_in; a_inv <= attr_in[INVALID]; next GOT_A.
- GOT_A, signal_wr=1:
  - res <= cond ? a : data_in.
  - res_attr: all bits 0 except INVALID = cond_inv | (cond ? a_inv : attr_in[INVALID]).
  - Next DONE.
- signal_wr=0: state and registers hold.
- Condition is any nonzero word, so a compare result of 1 selects A and 0 selects B.
- Latency: result is readable with signal_oe in the cycle after the edge that captured B.
- Output mux is combinational: data_out = signal_oe ? res : 0; attr_out = signal_oe ? res_attr : 0.
- signal_oe in any state returns the last completed result, or 0 before the first completion. No error is flagged; ordering is the scheduler's duty.
- signal_wr and signal_oe in the same cycle: output shows the pre-edge res; the write proceeds normally. A write of B in that cycle updates res only after the edge.
- No width arithmetic; A/B pass through unmodified, and cond reduction spans all DATA_WIDTH bits.

Decomposition:
- Shared package pu_select_pkg holds:
  - state enum (IDLE, GOT_COND, GOT_A, DONE), 2-bit encoding;
  - attribute bit-index constant INVALID, shared with the other PUs.
- No sub-module: FSM, capture registers and output mux are one flat block.

Test Plan:
- Reset: rst=0 for 2 cycles with signal_oe=1 -> data_out=0, attr_out=0. Drop rst asynchronously mid-cycle -> outputs clear before the next edge.
- True select: write cond=1, A=0x0000_00AA, B=0x0000_00BB, then signal_oe=1 -> data_out=0x0000_00AA, attr_out=0.
- False select with wide condition: cond=0 gives data_out=0x0000_00BB. Repeat with cond=0x8000_0000 -> 0x0000_00AA.
- Invalid propagation:
  - cond=1, A with attr_in=0001 -> attr_out=0001.
  - cond=0, same A invalid, B valid -> attr_out=0000.
  - cond invalid -> attr_out=0001 regardless of selection.
- Overlap and retention:
  - After result 0xAA, start a new sequence (cond=0, A=1) and read with signal_oe -> still 0xAA.
  - Write B=0x55 with signal_oe=1 in the same cycle -> 0xAA that cycle, 0x55 the next.
- Reset mid-operation: write cond=1 and A=0x11, pulse rst=0, then write cond=0, A=0x22, B=0x33 -> data_out=0x33, confirming restart from IDLE.
